// File: rtl/pool_nl_pkg.sv
// Shared types and helpers for the pool_nl datapath: accumulator FSM states
// and the accumulator-to-PE-width saturation used by every output path.
package pool_nl_pkg;

    localparam int DACC_DATA_W = 16;
    localparam int DACC_ACC_W  = 32;
    localparam int DACC_CNT_W  = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        OUT   = 2'd2
    } dacc_state_t;

    // The value fits when every bit above the result's sign bit matches it.
    function automatic logic [DACC_DATA_W-1:0] sat_to_data(input logic [DACC_ACC_W-1:0] acc);
        logic [DACC_ACC_W-DACC_DATA_W:0] upper;
        upper = acc[DACC_ACC_W-1:DACC_DATA_W-1];
        if (upper == '0 || upper == '1)
            return acc[DACC_DATA_W-1:0];
        else if (acc[DACC_ACC_W-1])
            return {1'b1, {(DACC_DATA_W-1){1'b0}}};
        else
            return {1'b0, {(DACC_DATA_W-1){1'b1}}};
    endfunction

endpackage

// File: rtl/dense_sat_relu.sv
// Combinational output stage: optional ReLU followed by saturation from the
// accumulator width down to the PE data width.
module dense_sat_relu
    import pool_nl_pkg::*;
#(
    parameter int DATA_W = DACC_DATA_W,
    parameter int ACC_W  = DACC_ACC_W
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic              relu_en,
    output logic [DATA_W-1:0] result
);

    always_comb begin
        if (relu_en && acc[ACC_W-1])
            result = '0;
        else
            result = sat_to_data(acc);
    end

endmodule

// File: rtl/dense_accumulator.sv
// Sums densing partials over all chunks of one neuron (bias preloaded), then
// presents the ReLU'd, saturated result on a valid/ready handshake.
module dense_accumulator
    import pool_nl_pkg::*;
#(
    parameter int DATA_W = DACC_DATA_W,
    parameter int ACC_W  = DACC_ACC_W,
    parameter int CNT_W  = DACC_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  cfg_num_chunks,
    input  logic              cfg_relu_en,
    input  logic [DATA_W-1:0] bias,
    input  logic              part_valid,
    input  logic [DATA_W-1:0] part_data,
    output logic              part_ready,
    output logic              busy,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready
);

    dacc_state_t       state;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_sum;
    logic [CNT_W-1:0]  chunk_cnt;
    logic [CNT_W-1:0]  num_chunks;
    logic              relu_en;
    logic              last_chunk;
    logic [DATA_W-1:0] result;

    // The result is taken from the sum including the final partial so it can
    // be registered on the same edge that accepts that partial.
    assign acc_sum    = acc + {{(ACC_W-DATA_W){part_data[DATA_W-1]}}, part_data};
    assign last_chunk = (chunk_cnt == num_chunks - CNT_W'(1));
    assign part_ready = (state == ACCUM);
    assign busy       = (state != IDLE);

    dense_sat_relu #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_sat_relu (
        .acc     (acc_sum),
        .relu_en (relu_en),
        .result  (result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            acc        <= '0;
            chunk_cnt  <= '0;
            num_chunks <= '0;
            relu_en    <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc        <= {{(ACC_W-DATA_W){bias[DATA_W-1]}}, bias};
                        chunk_cnt  <= '0;
                        num_chunks <= (cfg_num_chunks == '0) ? CNT_W'(1) : cfg_num_chunks;
                        relu_en    <= cfg_relu_en;
                        state      <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (part_valid) begin
                        acc       <= acc_sum;
                        chunk_cnt <= chunk_cnt + CNT_W'(1);
                        if (last_chunk) begin
                            out_data  <= result;
                            out_valid <= 1'b1;
                            state     <= OUT;
                        end
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dense_accumulator.sv
// Directed bench for dense_accumulator: a neuron-level model checked every
// cycle, plus literal results for each directed scenario.
module tb_dense_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [11:0] cfg_num_chunks;
    logic        cfg_relu_en;
    logic [15:0] bias;
    logic        part_valid;
    logic [15:0] part_data;
    logic        part_ready;
    logic        busy;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready;

    int assert_count = 0;
    int fail_count   = 0;

    dense_accumulator dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .cfg_num_chunks (cfg_num_chunks),
        .cfg_relu_en    (cfg_relu_en),
        .bias           (bias),
        .part_valid     (part_valid),
        .part_data      (part_data),
        .part_ready     (part_ready),
        .busy           (busy),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_ready      (out_ready)
    );

    always #5 clk = ~clk;

    function automatic int model_result(input int s, input bit r);
        int v;
        v = s;
        if (r && v < 0) v = 0;
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        return v;
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        assert_count++;
        if (actual != expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Neuron-level model: phase 0 waiting, 1 collecting partials, 2 result pending.
    int m_phase = 0, m_sum = 0, m_cnt = 0, m_n = 1, m_out = 0;
    bit m_relu = 0, m_valid = 0, model_live = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0; m_sum = 0; m_cnt = 0; m_valid = 0; m_out = 0;
            model_live = 1;
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_sum   = int'($signed(bias));
                    m_n     = (cfg_num_chunks == 12'd0) ? 1 : int'(cfg_num_chunks);
                    m_relu  = cfg_relu_en;
                    m_cnt   = 0;
                    m_phase = 1;
                end
                1: if (part_valid) begin
                    m_sum += int'($signed(part_data));
                    m_cnt++;
                    if (m_cnt == m_n) begin
                        m_out   = model_result(m_sum, m_relu);
                        m_valid = 1;
                        m_phase = 2;
                    end
                end
                2: if (out_ready) begin
                    m_valid = 0;
                    m_phase = 0;
                end
                default: m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            check("model part_ready", int'(part_ready), (m_phase == 1) ? 1 : 0);
            check("model busy", int'(busy), (m_phase != 0) ? 1 : 0);
            check("model out_valid", int'(out_valid), int'(m_valid));
            check("model out_data", int'($signed(out_data)), m_out);
        end
    end

    task automatic applyStimulus(input int b, input int n, input bit r, input int parts[$]);
        @(negedge clk);
        start = 1'b1; bias = 16'(b); cfg_num_chunks = 12'(n); cfg_relu_en = r;
        foreach (parts[i]) begin
            @(negedge clk);
            start = 1'b0; part_valid = 1'b1; part_data = 16'(parts[i]);
        end
        @(negedge clk);
        start = 1'b0; part_valid = 1'b0;
    endtask

    // Called on the first negedge after the last partial was driven.
    task automatic checkOutput(input string name, input int expected, input int hold_cycles,
                               input bit pulse_parts);
        int k;
        check({name, " latency"}, int'(out_valid), 1);
        k = 0;
        while (!out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        check({name, " data"}, int'($signed(out_data)), expected);
        for (int i = 0; i < hold_cycles; i++) begin
            part_valid = pulse_parts && (i % 2 == 0);
            part_data  = 16'd1000;
            @(negedge clk);
            check({name, " hold data"}, int'($signed(out_data)), expected);
            check({name, " hold valid"}, int'(out_valid), 1);
            check({name, " hold part_ready"}, int'(part_ready), 0);
        end
        part_valid = pulse_parts;
        out_ready  = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({name, " released"}, int'(out_valid), 0);
        @(negedge clk);
        part_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int parts[$];
        rst = 1'b1; start = 1'b0; cfg_num_chunks = '0; cfg_relu_en = 1'b0;
        bias = '0; part_valid = 1'b0; part_data = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset out_valid", int'(out_valid), 0);
        check("reset out_data", int'(out_data), 0);
        check("reset busy", int'(busy), 0);
        check("reset part_ready", int'(part_ready), 0);
        rst = 1'b0;

        parts = '{100, -20, 7};
        applyStimulus(5, 3, 1'b0, parts);
        checkOutput("basic", 92, 3, 1'b0);

        parts = '{-300, 100};
        applyStimulus(0, 2, 1'b1, parts);
        checkOutput("relu", 0, 0, 1'b0);

        parts = '{30000, 30000};
        applyStimulus(0, 2, 1'b0, parts);
        checkOutput("sat_pos", 32767, 0, 1'b0);

        parts = '{-30000, -30000};
        applyStimulus(0, 2, 1'b0, parts);
        checkOutput("sat_neg", -32768, 0, 1'b0);

        parts = '{5};
        applyStimulus(10, 1, 1'b0, parts);
        checkOutput("backpressure", 15, 10, 1'b1);
        parts = '{4};
        applyStimulus(0, 1, 1'b0, parts);
        checkOutput("after_bp", 4, 0, 1'b0);

        parts = '{3};
        applyStimulus(-7, 0, 1'b0, parts);
        checkOutput("zero_chunks", -4, 0, 1'b0);

        // Reset after the first of three partials.
        @(negedge clk);
        start = 1'b1; bias = 16'd50; cfg_num_chunks = 12'd3; cfg_relu_en = 1'b0;
        @(negedge clk);
        start = 1'b0; part_valid = 1'b1; part_data = 16'd10;
        @(negedge clk);
        part_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midreset out_valid", int'(out_valid), 0);
        check("midreset out_data", int'(out_data), 0);
        check("midreset busy", int'(busy), 0);
        check("midreset part_ready", int'(part_ready), 0);
        parts = '{1};
        applyStimulus(1, 1, 1'b0, parts);
        checkOutput("after_reset", 2, 0, 1'b0);

        // Gapped partials with a stray start carrying different config.
        @(negedge clk);
        start = 1'b1; bias = 16'd2; cfg_num_chunks = 12'd3; cfg_relu_en = 1'b0;
        @(negedge clk);
        start = 1'b0; part_valid = 1'b1; part_data = 16'd10;
        @(negedge clk);
        part_valid = 1'b0;
        @(negedge clk);
        start = 1'b1; bias = 16'd999; cfg_num_chunks = 12'd1; cfg_relu_en = 1'b1;
        part_valid = 1'b1; part_data = 16'd20;
        @(negedge clk);
        start = 1'b0; part_valid = 1'b0;
        check("gapped still busy", int'(out_valid), 0);
        @(negedge clk);
        @(negedge clk);
        part_valid = 1'b1; part_data = -16'sd5;
        @(negedge clk);
        part_valid = 1'b0;
        checkOutput("gapped", 27, 0, 1'b0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/dense_accumulator.md
Name: dense_accumulator

Overview:
- Sits directly downstream of the densing stage in pool_nl.
- Densing emits one signed partial dot-product per 9-element chunk of a fully-connected row. This block sums those partials over all chunks of one output neuron, adds the neuron bias, and optionally applies ReLU.
- It then saturates the result to the PE data width and presents it on a valid/ready handshake to the output writer.

Parameters:
- DATA_W, 16, signed width of partial sums, bias and result; equals `WID_PE_BITS.
- ACC_W, 32, signed internal accumulator width.
- CNT_W, 12, width of the chunk counter and chunk-count configuration.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse: begin a new neuron; samples cfg_num_chunks, cfg_relu_en and bias.
- cfg_num_chunks  in  CNT_W  number of partials per neuron, ceil(row_len/9); 0 is treated as 1.
- cfg_relu_en  in  1  1 = clamp negative results to 0.
- bias  in  DATA_W  signed bias for this neuron.
- part_valid  in  1  partial sum from densing valid this cycle.
- part_data  in  DATA_W  signed partial sum (densing out_dense_data).
- part_ready  out  1  block accepts a partial this cycle.
- busy  out  1  neuron in progress (ACCUM or OUT).
- out_valid  out  1  result available.
- out_data  out  DATA_W  saturated, optionally ReLU'd, result.
- out_ready  in  1  downstream accepts result.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset state: FSM = IDLE; acc = 0; chunk_cnt = 0; part_ready = 0; busy = 0; out_valid = 0; out_data = 0. Reset mid-operation drops any in-flight neuron with no output.
- FSM states: IDLE, ACCUM, OUT.
- IDLE:
  - part_ready = 0.
  - On start: acc <= sign-extended bias; chunk_cnt <= 0; latch num_chunks (0 becomes 1) and relu_en; go to ACCUM.
  - part_valid in IDLE is ignored.
- ACCUM:
  - part_ready = 1.
  - A partial is accepted on a cycle with part_valid & part_ready: acc <= acc + sign-extended part_data; chunk_cnt++.
  - When the accepted partial is chunk number num_chunks-1, go to OUT the next cycle.
- OUT:
  - Result = sat(relu(acc)), registered into out_data on entry, together with out_valid = 1.
  - relu(x) = 0 if relu_en and x < 0, else x.
  - sat clamps to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - out_data and out_valid hold stable until out_ready.
  - On out_valid & out_ready: out_valid <= 0; return to IDLE.
- Latency: result is visible 1 cycle after the last partial is accepted.
- Throughput: one partial per cycle.
- Accumulator overflow: ACC_W wraps. With ACC_W = 32 and DATA_W = 16 this is unreachable for cfg_num_chunks < 2^16; no flag is raised.
- start outside IDLE: ignored, no effect on the current neuron.
- Back-to-back neurons: start is sampled only in IDLE. The earliest next start is the cycle after the output handshake completes.
- busy = (state != IDLE).
- Arithmetic is two's complement throughout. Bias is added at start, not at the end, so saturation applies once to the full sum.

Decomposition:
- Shared package pool_nl_pkg holds:
  - state enum dacc_state_t {IDLE, ACCUM, OUT};
  - a function sat_to_data(acc) returning DATA_W;
  - localparams for DATA_W and ACC_W defaults.
- One sub-module is natural: dense_sat_relu, combinational, ACC_W in, DATA_W out, with a relu_en input. It is reused by the pooling output path.
- The FSM and accumulator stay in the top module.

Test Plan:
- Basic sum: bias = 5, cfg_num_chunks = 3, relu off; partials 100, -20, 7 on consecutive cycles. Expect out_valid one cycle after the third partial, out_data = 92, held until out_ready.
- ReLU and saturation:
  - bias = 0, 2 chunks, relu on, partials -300 and 100 → out_data = 0.
  - Relu off, partials 30000 and 30000 → 32767.
  - Relu off, partials -30000 and -30000 → -32768.
- Backpressure: out_ready held low 10 cycles. Expect out_data stable and part_ready = 0 throughout. part_valid pulses during this window are not accumulated into the next neuron (result for bias = 0, 1 chunk, partial 4 is 4).
- Zero chunk count: cfg_num_chunks = 0, bias = -7, one partial 3 → treated as 1 chunk, out_data = -4.
- Reset mid-ACCUM: rst after 1 of 3 partials. Expect all outputs 0 and IDLE the next cycle. A fresh neuron (bias = 1, 1 chunk, partial 1) gives 2.
- Gapped input and stray start: partials with idle cycles between them, plus a start pulse during ACCUM. Expect the sum unaffected and num_chunks unchanged.
